// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the framed single-wire serial master.
package spi_frame_pkg;

  typedef enum logic [1:0] {
    OP_START   = 2'd0,
    OP_CFG     = 2'd1,
    OP_READ    = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  localparam logic [7:0] HDR_START = 8'hA5;
  localparam logic [7:0] HDR_CFG   = 8'h3C;
  localparam logic [7:0] HDR_READ  = 8'hC3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HDR   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_TURN  = 3'd4;
  localparam logic [2:0] ST_RDATA = 3'd5;
  localparam logic [2:0] ST_END   = 3'd6;
  localparam logic [2:0] ST_RESP  = 3'd7;

  function automatic logic [7:0] hdr_of(input logic [1:0] op);
    case (op)
      2'd0:    return HDR_START;
      2'd1:    return HDR_CFG;
      2'd2:    return HDR_READ;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_frame_master_shifter.sv
// 9-bit LSB-first shift register with a step counter, used for both
// transmit (bit 0 drives the line) and receive (rx enters at the top).
module spi_bit_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [8:0] din,
  input  logic       step,
  input  logic       rx,
  output logic [8:0] q,
  output logic [3:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= din;
      cnt <= '0;
    end else if (step) begin
      q   <= {rx, q[8:1]};
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/spi_frame_master.sv
// Command sequencer for the framed single-wire serial link: header/data
// transmit, bus turnaround, 9-bit read capture, suspend watchdog, IFG.
module spi_frame_master
  import spi_frame_pkg::*;
#(
  parameter int TA_CYCLES  = 2,
  parameter int IFG_CYCLES = 2,
  parameter int SUSP_MAX   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [8:0] rsp_rdata,
  output logic       rsp_err,
  output logic       frame,
  output logic       serial_o,
  output logic       serial_oe,
  input  logic       serial_i,
  input  logic       suspend
);

  localparam int TW = $clog2(TA_CYCLES + 1);
  localparam int SW = $clog2(SUSP_MAX);
  localparam int IW = $clog2(IFG_CYCLES + 1);
  localparam logic [TW-1:0] TA_LAST   = TW'(TA_CYCLES - 1);
  localparam logic [SW-1:0] SUSP_LAST = SW'(SUSP_MAX - 1);
  localparam logic [IW-1:0] IFG_INIT  = IW'(IFG_CYCLES);

  logic [2:0]    state;
  op_e           op_q;
  logic [7:0]    wdata_q;
  logic          err_q;
  logic [8:0]    rdata_q;
  logic [SW-1:0] susp_cnt;
  logic [TW-1:0] ta_cnt;
  logic [IW-1:0] ifg_cnt;

  logic       sh_load;
  logic [8:0] sh_din;
  logic [8:0] sh_q;
  logic [3:0] sh_cnt;

  logic accept, bitwork, step, timeout;
  logic hdr_last, data_last, rd_last;

  assign accept    = cmd_valid & cmd_ready;
  assign bitwork   = (state == ST_HDR) | (state == ST_DATA) |
                     (state == ST_RDATA);
  assign step      = bitwork & ~suspend;
  assign timeout   = bitwork & suspend & (susp_cnt == SUSP_LAST);
  assign hdr_last  = (state == ST_HDR) & step & (sh_cnt == 4'd7);
  assign data_last = (state == ST_DATA) & step & (sh_cnt == 4'd7);
  assign rd_last   = (state == ST_RDATA) & step & (sh_cnt == 4'd8);

  always_comb begin
    sh_load = 1'b0;
    sh_din  = '0;
    unique case (1'b1)
      accept: begin
        sh_load = 1'b1;
        sh_din  = {1'b0, hdr_of(cmd_op)};
      end
      hdr_last: begin
        sh_load = 1'b1;
        sh_din  = (op_q == OP_CFG) ? {1'b0, wdata_q} : 9'd0;
      end
      default: ;
    endcase
  end

  spi_bit_shifter u_shift (
    .clk  (clk),
    .rst  (rst),
    .load (sh_load),
    .din  (sh_din),
    .step (step),
    .rx   (serial_i),
    .q    (sh_q),
    .cnt  (sh_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_START;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      susp_cnt <= '0;
      ta_cnt   <= '0;
      ifg_cnt  <= '0;
    end else begin
      susp_cnt <= (bitwork & suspend) ? susp_cnt + 1'b1 : '0;
      unique case (state)
        ST_IDLE: begin
          if (ifg_cnt != '0) ifg_cnt <= ifg_cnt - 1'b1;
          if (accept) begin
            op_q    <= op_e'(cmd_op);
            wdata_q <= cmd_wdata;
            err_q   <= (cmd_op == OP_ILLEGAL);
            // illegal ops skip the frame but still pass through END
            state   <= (cmd_op == OP_ILLEGAL) ? ST_END : ST_SETUP;
          end
        end
        ST_SETUP: state <= ST_HDR;
        ST_HDR: begin
          if (timeout) begin
            err_q <= 1'b1;
            state <= ST_END;
          end else if (hdr_last) begin
            ta_cnt <= '0;
            unique case (op_q)
              OP_CFG:  state <= ST_DATA;
              OP_READ: state <= ST_TURN;
              default: state <= ST_END;
            endcase
          end
        end
        ST_DATA: begin
          if (timeout) begin
            err_q <= 1'b1;
            state <= ST_END;
          end else if (data_last) begin
            state <= ST_END;
          end
        end
        ST_TURN: begin
          if (ta_cnt == TA_LAST) state <= ST_RDATA;
          else ta_cnt <= ta_cnt + 1'b1;
        end
        ST_RDATA: begin
          if (timeout) begin
            err_q <= 1'b1;
            state <= ST_END;
          end else if (rd_last) begin
            state <= ST_END;
          end
        end
        ST_END: begin
          ifg_cnt <= IFG_INIT;
          rdata_q <= (op_q == OP_READ && !err_q) ? sh_q : 9'd0;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          if (ifg_cnt != '0) ifg_cnt <= ifg_cnt - 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = ~rst & (state == ST_IDLE) & (ifg_cnt == '0);
  assign frame     = (state == ST_SETUP) | (state == ST_HDR) |
                     (state == ST_DATA) | (state == ST_TURN) |
                     (state == ST_RDATA);
  assign serial_oe = (state == ST_SETUP) | (state == ST_HDR) |
                     (state == ST_DATA);
  assign serial_o  = ((state == ST_HDR) | (state == ST_DATA)) & sh_q[0];
  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = (state == ST_RESP) & err_q;
  assign rsp_rdata = (state == ST_RESP) ? rdata_q : 9'd0;

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench for spi_frame_master: directed commands, slave model,
// frame/stream recorder and response monitor.
module tb_spi_frame_master;

  localparam int TA  = 2;
  localparam int IFG = 2;
  localparam int SM  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [8:0] rsp_rdata;
  logic       rsp_err;
  logic       frame;
  logic       serial_o;
  logic       serial_oe;
  logic       serial_i = 1'b0;
  logic       suspend  = 1'b0;

  spi_frame_master #(
    .TA_CYCLES  (TA),
    .IFG_CYCLES (IFG),
    .SUSP_MAX   (SM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .frame     (frame),
    .serial_o  (serial_o),
    .serial_oe (serial_oe),
    .serial_i  (serial_i),
    .suspend   (suspend)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] rdata;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sbq[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // response monitor
  initial forever begin
    @(negedge clk);
    if (rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected none");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  // frame recorder, suspend plan and read-slave model
  int flen = 0, foel = 0, gap = 0, rises = 0;
  int last_len = 0, last_oel = 0;
  logic [63:0] strm = '0, last_strm = '0;
  bit infr = 1'b0;
  int s0 = -1, sl = 0;
  logic [8:0] rd_word = '0;

  initial forever begin
    @(negedge clk);
    if (frame === 1'b1) begin
      if (!infr) begin
        infr = 1'b1;
        flen = 0;
        foel = 0;
        strm = '0;
        if (rises > 0) chk("ifg_gap_ge3", gap >= 3, 1);
        rises++;
      end
      if (flen < 64) strm[flen] = serial_o & serial_oe;
      suspend = (s0 >= 0 && flen >= s0 && flen < s0 + sl);
      serial_i = (!serial_oe && foel >= TA && foel < TA + 9) ?
                 rd_word[foel-TA] : 1'b0;
      if (!serial_oe) foel++;
      flen++;
    end else begin
      if (infr) begin
        infr      = 1'b0;
        last_len  = flen;
        last_oel  = foel;
        last_strm = strm;
        gap       = 0;
      end
      gap++;
      suspend  = 1'b0;
      serial_i = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] wd,
                       input logic [8:0] er, input logic ee,
                       input int el, input bit push);
    int w = 0;
    exp_t e;
    cmd_op    = op;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1");
      cmd_valid = 1'b0;
      return;
    end
    if (push) begin
      e.rdata = er;
      e.err   = ee;
      e.lat   = el;
      e.acc   = cyc + 1;
      sbq.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int w = 0;
    while (sbq.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_timeout: got %0d pending expected 0",
               sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  int r0;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cmd_ready, frame, serial_o, serial_oe,
                          rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    issue(2'd1, 8'h5A, 9'd0, 1'b0, 19, 1'b1);
    wait_done();
    chk("cfg_frame_len", last_len, 17);
    chk("cfg_stream", last_strm, {8'h5A, 8'h3C, 1'b0});

    rd_word = 9'h16D;
    issue(2'd2, 8'h00, 9'h16D, 1'b0, 11 + TA + 9, 1'b1);
    wait_done();
    chk("read_frame_len", last_len, 1 + 8 + TA + 9);
    chk("read_oe_low", last_oel, TA + 9);
    chk("read_hdr_stream", last_strm, {8'hC3, 1'b0});

    s0 = 5;
    sl = 3;
    issue(2'd1, 8'h5A, 9'd0, 1'b0, 22, 1'b1);
    wait_done();
    s0 = -1;
    chk("susp_frame_len", last_len, 20);
    chk("susp_stream", last_strm,
        {8'h5A, 2'b00, 1'b1, 4'b1111, 4'b1100, 1'b0});

    s0 = 1 + 8 + TA;
    sl = 16;
    rd_word = 9'h1FF;
    issue(2'd2, 8'h00, 9'd0, 1'b1, 1 + 8 + TA + 16 + 2, 1'b1);
    wait_done();
    s0 = -1;
    chk("abort_frame_len", last_len, 1 + 8 + TA + 16);

    issue(2'd0, 8'h00, 9'd0, 1'b0, 11, 1'b1);
    wait_done();
    chk("start_frame_len", last_len, 9);
    chk("start_stream", last_strm, {8'hA5, 1'b0});

    r0 = rises;
    issue(2'd3, 8'hFF, 9'd0, 1'b1, 2, 1'b1);
    wait_done();
    chk("illegal_no_frame", rises, r0);

    issue(2'd0, 8'h00, 9'd0, 1'b0, 11, 1'b1);
    issue(2'd0, 8'h00, 9'd0, 1'b0, 11, 1'b1);
    wait_done();
    chk("b2b_frames", rises, r0 + 2);

    issue(2'd1, 8'h33, 9'd0, 1'b0, 0, 1'b0);
    repeat (12) @(negedge clk);
    chk("in_data_frame", {frame, serial_oe}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_drop", {frame, serial_oe, cmd_ready}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_midreset", cmd_ready, 1);
    repeat (25) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
